// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU: opcodes, FSM states, flag positions.
package acc_cpu_pkg;

  localparam int unsigned OpW = 4;

  localparam logic [OpW-1:0] OpNop = 4'h0;
  localparam logic [OpW-1:0] OpLda = 4'h1;
  localparam logic [OpW-1:0] OpSta = 4'h2;
  localparam logic [OpW-1:0] OpAdd = 4'h3;
  localparam logic [OpW-1:0] OpSub = 4'h4;
  localparam logic [OpW-1:0] OpAnd = 4'h5;
  localparam logic [OpW-1:0] OpOr  = 4'h6;
  localparam logic [OpW-1:0] OpXor = 4'h7;
  localparam logic [OpW-1:0] OpLdi = 4'h8;
  localparam logic [OpW-1:0] OpShl = 4'h9;
  localparam logic [OpW-1:0] OpShr = 4'hA;
  localparam logic [OpW-1:0] OpJmp = 4'hB;
  localparam logic [OpW-1:0] OpJz  = 4'hC;
  localparam logic [OpW-1:0] OpJn  = 4'hD;
  localparam logic [OpW-1:0] OpJc  = 4'hE;
  localparam logic [OpW-1:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StMemRd  = 3'd2,
    StMemWr  = 3'd3,
    StExec   = 3'd4,
    StHalted = 3'd5
  } state_e;

  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 2;

  // Opcodes whose second operand comes from data memory.
  function automatic logic is_mem_alu(logic [OpW-1:0] op);
    return (op == OpLda) || (op == OpAdd) || (op == OpSub) ||
           (op == OpAnd) || (op == OpOr)  || (op == OpXor);
  endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Memory request/acknowledge bus; the core is master, the memory is slave.
interface acc_cpu_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: computes the new accumulator and {C,N,Z} for acc-writing ops.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [OpW-1:0] op_i,
  input  logic [DW-1:0]  acc_i,
  input  logic [DW-1:0]  b_i,
  input  logic           c_i,
  output logic [DW-1:0]  result_o,
  output logic [2:0]     flags_o,
  output logic           acc_we_o
);

  logic c;

  always_comb begin
    result_o = acc_i;
    c        = c_i;
    acc_we_o = 1'b1;
    unique case (op_i)
      OpLda, OpLdi: result_o = b_i;
      OpAdd:        {c, result_o} = {1'b0, acc_i} + {1'b0, b_i};
      OpSub: begin
        result_o = acc_i - b_i;
        c        = acc_i < b_i;
      end
      OpAnd: begin
        result_o = acc_i & b_i;
        c        = 1'b0;
      end
      OpOr: begin
        result_o = acc_i | b_i;
        c        = 1'b0;
      end
      OpXor: begin
        result_o = acc_i ^ b_i;
        c        = 1'b0;
      end
      OpShl: begin
        result_o = {acc_i[DW-2:0], 1'b0};
        c        = acc_i[DW-1];
      end
      OpShr: begin
        result_o = {1'b0, acc_i[DW-1:1]};
        c        = acc_i[0];
      end
      default: acc_we_o = 1'b0;
    endcase

    flags_o        = '0;
    flags_o[FlagZ] = (result_o == '0);
    flags_o[FlagN] = result_o[DW-1];
    flags_o[FlagC] = c;
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with handshaked instruction/data memories and halt/resume.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  acc_cpu_if.master     imem,
  acc_cpu_if.master     dmem,
  input  logic          resume,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic [2:0]    flags,
  output logic          halted
);

  if (DW < AW + OpW) begin : g_bad_width
    $error("acc_cpu_core: DW must be at least AW + 4");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [2:0]    flags_q, flags_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;

  logic [OpW-1:0] op;
  logic [AW-1:0]  operand;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_result;
  logic [2:0]     alu_flags;
  logic           alu_we;
  logic           unused_ir;

  assign op        = ir_q[DW-1:DW-OpW];
  assign operand   = ir_q[AW-1:0];
  assign unused_ir = ^ir_q;
  assign alu_b     = (op == OpLdi) ? {{(DW-AW){1'b0}}, operand} : mdr_q;

  acc_cpu_alu #(
    .DW (DW)
  ) u_alu (
    .op_i     (op),
    .acc_i    (acc_q),
    .b_i      (alu_b),
    .c_i      (flags_q[FlagC]),
    .result_o (alu_result),
    .flags_o  (alu_flags),
    .acc_we_o (alu_we)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      StFetch: begin
        if (imem.ack) begin
          ir_d    = imem.rdata;
          pc_d    = pc_q + AW'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_mem_alu(op))   state_d = StMemRd;
        else if (op == OpSta) state_d = StMemWr;
        else                  state_d = StExec;
      end
      StMemRd: begin
        if (dmem.ack) begin
          mdr_d   = dmem.rdata;
          state_d = StExec;
        end
      end
      StMemWr: begin
        if (dmem.ack) state_d = StFetch;
      end
      StExec: begin
        if (alu_we) begin
          acc_d   = alu_result;
          flags_d = alu_flags;
        end
        // pc was already incremented in FETCH, so a not-taken branch needs no update.
        unique case (op)
          OpJmp:   pc_d = operand;
          OpJz:    if (flags_q[FlagZ]) pc_d = operand;
          OpJn:    if (flags_q[FlagN]) pc_d = operand;
          OpJc:    if (flags_q[FlagC]) pc_d = operand;
          default: ;
        endcase
        state_d = (op == OpHlt) ? StHalted : StFetch;
      end
      StHalted: begin
        if (resume) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  // Fetch state is the reset state, so gate its request while reset is held.
  assign imem.req   = rst && (state_q == StFetch);
  assign imem.we    = 1'b0;
  assign imem.addr  = pc_q;
  assign imem.wdata = '0;

  assign dmem.req   = (state_q == StMemRd) || (state_q == StMemWr);
  assign dmem.we    = (state_q == StMemWr);
  assign dmem.addr  = operand;
  assign dmem.wdata = acc_q;

  assign pc     = pc_q;
  assign acc    = acc_q;
  assign flags  = flags_q;
  assign halted = (state_q == StHalted);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core with an instruction-level reference model and memory responders.
module tb_acc_cpu_core;

  logic        clk;
  logic        rst_n;
  logic        resume;
  logic [7:0]  pc;
  logic [15:0] acc;
  logic [2:0]  flags;
  logic        halted;

  acc_cpu_if #(.AW(8), .DW(16)) imem_bus ();
  acc_cpu_if #(.AW(8), .DW(16)) dmem_bus ();

  acc_cpu_core #(
    .DW (16),
    .AW (8)
  ) dut (
    .clk    (clk),
    .rst    (rst_n),
    .imem   (imem_bus),
    .dmem   (dmem_bus),
    .resume (resume),
    .pc     (pc),
    .acc    (acc),
    .flags  (flags),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem_arr [256];
  logic [15:0] dmem_arr [256];
  int i_wait, d_wait, i_cnt, d_cnt;

  assign imem_bus.rdata = imem_arr[imem_bus.addr];
  assign dmem_bus.rdata = dmem_arr[dmem_bus.addr];
  assign imem_bus.ack   = imem_bus.req && (i_cnt == i_wait);
  assign dmem_bus.ack   = dmem_bus.req && (d_cnt == d_wait);

  always @(posedge clk) begin
    if (!imem_bus.req || imem_bus.ack) i_cnt <= 0;
    else                               i_cnt <= i_cnt + 1;
    if (!dmem_bus.req || dmem_bus.ack) d_cnt <= 0;
    else                               d_cnt <= d_cnt + 1;
  end

  int cmp_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference model.
  logic [7:0]  m_pc;
  logic [15:0] m_acc;
  logic        m_z, m_n, m_c;
  logic [15:0] m_dmem [256];
  logic [23:0] exp_wr [$];
  int          rise_q [$];
  int          cyc = 0;
  int          wr_cnt = 0;
  logic        fetch_prev = 1'b0;

  task automatic model_reset();
    m_pc = 8'h00; m_acc = 16'h0000; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    for (int i = 0; i < 256; i++) m_dmem[i] = dmem_arr[i];
  endtask

  task automatic set_acc(input logic [15:0] v);
    m_acc = v;
    m_z   = (v == 16'h0000);
    m_n   = (v >= 16'h8000);
  endtask

  task automatic model_step();
    logic [15:0] ins, d;
    logic [7:0]  opd;
    int          sum;
    ins  = imem_arr[m_pc];
    opd  = ins[7:0];
    d    = m_dmem[opd];
    m_pc = m_pc + 8'd1;
    case (ins[15:12])
      4'h1: set_acc(d);
      4'h2: begin m_dmem[opd] = m_acc; exp_wr.push_back({opd, m_acc}); end
      4'h3: begin sum = int'(m_acc) + int'(d); m_c = (sum > 65535); set_acc(16'(sum)); end
      4'h4: begin m_c = (m_acc < d); set_acc(m_acc - d); end
      4'h5: begin m_c = 1'b0; set_acc(m_acc & d); end
      4'h6: begin m_c = 1'b0; set_acc(m_acc | d); end
      4'h7: begin m_c = 1'b0; set_acc(m_acc ^ d); end
      4'h8: set_acc({8'h00, opd});
      4'h9: begin m_c = (m_acc >= 16'h8000); set_acc(16'(int'(m_acc) * 2)); end
      4'hA: begin m_c = (m_acc % 2 == 1); set_acc(m_acc / 2); end
      4'hB: m_pc = opd;
      4'hC: if (m_z) m_pc = opd;
      4'hD: if (m_n) m_pc = opd;
      4'hE: if (m_c) m_pc = opd;
      default: ;
    endcase
  endtask

  // Compare process: architectural state at every instruction boundary, plus every data write.
  logic [23:0] wr_exp;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
        fetch_prev = 1'b0;
        exp_wr.delete();
        rise_q.delete();
        wr_cnt = 0;
      end else begin
        if (dmem_bus.req && dmem_bus.we && dmem_bus.ack) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 32'(dmem_bus.addr), 32'hFFFF_FFFF);
          end else begin
            wr_exp = exp_wr.pop_front();
            check("write_addr", 32'(dmem_bus.addr), 32'(wr_exp[23:16]));
            check("write_data", 32'(dmem_bus.wdata), 32'(wr_exp[15:0]));
          end
          dmem_arr[dmem_bus.addr] = dmem_bus.wdata;
        end
        if (imem_bus.req && !fetch_prev) begin
          rise_q.push_back(cyc);
          check("fetch_pc", 32'(pc), 32'(m_pc));
          check("fetch_acc", 32'(acc), 32'(m_acc));
          check("fetch_flags", 32'(flags), 32'({m_c, m_n, m_z}));
          model_step();
        end
        fetch_prev = imem_bus.req;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem_arr[i] = 16'hF000;
      dmem_arr[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  task automatic wait_dreq(input string name);
    int n = 0;
    while (!dmem_bus.req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dmem_bus.req), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  int cycles, viol;
  logic stable;

  initial begin
    rst_n = 1'b0; resume = 1'b0; i_wait = 0; d_wait = 0;

    // Reset asserted while a data read is outstanding.
    clear_mem();
    imem_arr[0] = 16'h8001; imem_arr[1] = 16'hA000; imem_arr[2] = 16'h807F;
    imem_arr[3] = 16'h1010; imem_arr[4] = 16'hF000;
    dmem_arr[8'h10] = 16'h1234;
    d_wait = 5;
    do_reset();
    wait_dreq("t1_dreq_seen");
    @(negedge clk);
    check("t1_pre_acc", 32'(acc), 32'h007F);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_dreq", 32'(dmem_bus.req), 32'd0);
    check("t1_rst_ireq", 32'(imem_bus.req), 32'd0);
    check("t1_rst_pc", 32'(pc), 32'd0);
    check("t1_rst_acc", 32'(acc), 32'd0);
    check("t1_rst_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("t1_first_ireq", 32'(imem_bus.req), 32'd1);
    check("t1_first_iaddr", 32'(imem_bus.addr), 32'h00);
    run_to_halt("t1_halt");
    check("t1_acc", 32'(acc), 32'h1234);
    check("t1_flags", 32'(flags), 32'b100);
    check("t1_pc", 32'(pc), 32'h05);

    // LDI 5; ADD 0xFFFB -> 0 with carry; JZ taken.
    clear_mem();
    imem_arr[0] = 16'h8005; imem_arr[1] = 16'h3010; imem_arr[2] = 16'hC020;
    imem_arr[3] = 16'h8077; imem_arr[4] = 16'hF000; imem_arr[8'h20] = 16'hF000;
    dmem_arr[8'h10] = 16'hFFFB;
    i_wait = 2; d_wait = 1;
    do_reset();
    run_to_halt("t2_halt");
    check("t2_acc", 32'(acc), 32'h0000);
    check("t2_flags", 32'(flags), 32'b101);
    check("t2_pc", 32'(pc), 32'h21);

    // LDI 3; SUB 5 -> 0xFFFE; JZ not taken; JC taken.
    clear_mem();
    imem_arr[0] = 16'h8003; imem_arr[1] = 16'h4011; imem_arr[2] = 16'hC050;
    imem_arr[3] = 16'hE040; imem_arr[4] = 16'hF000;
    imem_arr[8'h40] = 16'hF000; imem_arr[8'h50] = 16'h8099; imem_arr[8'h51] = 16'hF000;
    dmem_arr[8'h11] = 16'h0005;
    i_wait = 1; d_wait = 2;
    do_reset();
    run_to_halt("t3_halt");
    check("t3_acc", 32'(acc), 32'hFFFE);
    check("t3_flags", 32'(flags), 32'b110);
    check("t3_pc", 32'(pc), 32'h41);

    // STA with three wait states: request held stable for four cycles.
    clear_mem();
    imem_arr[0] = 16'h80AB; imem_arr[1] = 16'h2030; imem_arr[2] = 16'hF000;
    i_wait = 0; d_wait = 3;
    do_reset();
    wait_dreq("t4_dreq_seen");
    cycles = 0; stable = 1'b1;
    while (dmem_bus.req && cycles < 20) begin
      cycles++;
      if (!(dmem_bus.we && dmem_bus.addr == 8'h30 && dmem_bus.wdata == 16'h00AB)) stable = 1'b0;
      if (acc != 16'h00AB || flags != 3'b000) stable = 1'b0;
      @(negedge clk);
    end
    check("t4_req_cycles", 32'(cycles), 32'd4);
    check("t4_stable", 32'(stable), 32'd1);
    run_to_halt("t4_halt");
    check("t4_writes", 32'(wr_cnt), 32'd1);
    check("t4_mem", 32'(dmem_arr[8'h30]), 32'h00AB);
    check("t4_acc", 32'(acc), 32'h00AB);
    check("t4_flags", 32'(flags), 32'b000);

    // HLT at 0xFF: pc wraps, core stays quiet until resumed.
    clear_mem();
    imem_arr[0] = 16'hB0FF; imem_arr[8'hFF] = 16'hF000;
    i_wait = 0; d_wait = 0;
    do_reset();
    run_to_halt("t5_halt");
    check("t5_pc_wrap", 32'(pc), 32'h00);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_bus.req || dmem_bus.req || !halted) viol++;
    end
    check("t5_quiet", 32'(viol), 32'd0);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("t5_resume_ireq", 32'(imem_bus.req), 32'd1);
    check("t5_resume_iaddr", 32'(imem_bus.addr), 32'h00);
    check("t5_resume_halted", 32'(halted), 32'd0);
    run_to_halt("t5_halt2");

    // Zero-wait instruction latencies: NOP, ADD, STA, LDI.
    clear_mem();
    imem_arr[0] = 16'h0000; imem_arr[1] = 16'h3010; imem_arr[2] = 16'h2031;
    imem_arr[3] = 16'h8001; imem_arr[4] = 16'hF000;
    dmem_arr[8'h10] = 16'h0002;
    do_reset();
    run_to_halt("t6_halt");
    check("t6_rises", 32'(rise_q.size()), 32'd5);
    if (rise_q.size() >= 5) begin
      check("t6_lat_nop", 32'(rise_q[1] - rise_q[0]), 32'd3);
      check("t6_lat_add", 32'(rise_q[2] - rise_q[1]), 32'd4);
      check("t6_lat_sta", 32'(rise_q[3] - rise_q[2]), 32'd3);
      check("t6_lat_ldi", 32'(rise_q[4] - rise_q[3]), 32'd3);
    end
    check("t6_acc", 32'(acc), 32'h0001);
    check("t6_mem", 32'(dmem_arr[8'h31]), 32'h0002);
    check("t6_pending_writes", 32'(exp_wr.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised multi-cycle accumulator CPU core. It is the next generation of the single-cycle cpu top built from pc, ins, cu, acc, alu and Datastorage.
- Memories move outside the core and are reached through req/ack handshakes, so they can have wait states.
- Adds Z/N/C flags, conditional jumps, shifts, and a halt/resume mechanism.
- Sits between an instruction memory and a data memory. pc, acc and flags are exported for debug.

Parameters:
DW, 16, data/accumulator width; must satisfy DW >= 4 + AW
AW, 8, instruction and data address width
(opcode width fixed at 4 bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
imem_req  output  1  instruction fetch request
imem_addr  output  AW  fetch address (= pc)
imem_rdata  input  DW  instruction word
imem_ack  input  1  fetch completes this cycle
dmem_req  output  1  data access request
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  AW  data address (= ir operand)
dmem_wdata  output  DW  write data (= acc)
dmem_rdata  input  DW  read data
dmem_ack  input  1  data access completes this cycle
resume  input  1  leave HALTED
pc  output  AW  program counter
acc  output  DW  accumulator
flags  output  3  {C,N,Z}
halted  output  1  core in HALTED state

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH; pc, acc, flags, ir and mdr = 0; all req outputs 0 immediately, including mid-transaction.
- Instruction word: ir[DW-1:DW-4] = opcode, ir[AW-1:0] = operand (address or zero-extended immediate).
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 LDI, 9 SHL, A SHR, B JMP, C JZ, D JN, E JC, F HLT.
- Handshake rules:
  - req is held, with addr/we/wdata stable, until the cycle ack=1. Ack in the same cycle as req is legal (zero wait).
  - Ack while no request is pending is ignored.
- FSM:
  - FETCH: imem_req=1. On imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps 2^AW-1 -> 0), go to DECODE.
  - DECODE: LDA/ADD/SUB/AND/OR/XOR go to MEM_RD; STA goes to MEM_WR; all others go to EXEC.
  - MEM_RD: dmem_req=1, we=0. On dmem_ack: mdr<=dmem_rdata, go to EXEC.
  - MEM_WR: dmem_req=1, we=1, wdata=acc. On dmem_ack go to FETCH. acc and flags are unchanged.
  - EXEC: update acc/flags or pc (below), go to FETCH. HLT goes to HALTED.
  - HALTED: halted=1, no requests. resume=1 goes to FETCH at the current pc.
- Instruction latency with zero-wait memories:
  - NOP/LDI/SHx/Jxx: 3 cycles.
  - Memory ALU ops: 4 cycles.
  - STA: 3 cycles.
- Arithmetic and flags:
  - ADD: {C,acc} = acc + mdr.
  - SUB: acc = acc - mdr, modulo 2^DW. C = borrow (acc < mdr unsigned).
  - AND/OR/XOR: C=0.
  - SHL: C = acc[DW-1], LSB filled with 0. SHR: C = acc[0], MSB filled with 0.
  - LDA / LDI: load mdr / zero-extended operand; C unchanged.
  - Every acc-writing op sets Z = (new acc == 0) and N = new acc[DW-1].
  - NOP, STA, jumps and HLT leave flags unchanged.
- Jumps:
  - JMP: pc <= operand.
  - JZ/JN/JC: pc <= operand if Z/N/C is set, else pc is unchanged (already incremented).
- HLT: pc already points past the HLT instruction.

Decomposition:
- Package acc_cpu_pkg holds:
  - opcode localparams
  - FSM state encoding (FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALTED)
  - flag bit indices (Z=0, N=1, C=2)
- One sub-module, acc_cpu_alu: combinational. Inputs: opcode, acc, operand/mdr, C. Outputs: result and new flags. The core owns all state.

Test Plan:
- Drive rst=0 asynchronously while in MEM_RD with dmem_req=1 -> dmem_req, pc, acc and flags are 0 immediately. After release, first imem_addr=0x00.
- Program LDI 0x05; ADD [0x10] with mem[0x10]=0xFFFB; JZ 0x20 -> acc=0x0000, Z=1, C=1, N=0, next fetch at 0x20.
- acc=0x0003, SUB [x] with mem[x]=0x0005 -> acc=0xFFFE, N=1, C=1, Z=0. Following JC 0x40 is taken; JZ is not taken.
- STA 0x30 with dmem_ack delayed 3 cycles -> dmem_req=1, we=1, addr=0x30, wdata=acc stable for 4 cycles; exactly one write; acc and flags unchanged.
- HLT placed at 0xFF -> pc wraps to 0x00, halted=1, no requests for 10 cycles. One-cycle resume pulse -> imem_req with imem_addr=0x00 on the next cycle.
- Zero-wait memories, count cycles between imem_req rising edges -> NOP=3, ADD=4, STA=3, LDI=3.
